spi_regbank: RTL and testbench
==============================

SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 SHALL have parameter ADDR_W, default 7: address field width in bits.
REQ-002 SHALL have parameter DATA_W, default 8: data field and register width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 5: number of implemented registers, legal range 1..2**ADDR_W.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for SPI inputs, minimum 2.
REQ-005 SHALL have port clk, input, 1: system clock; all logic in this domain.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port sclk, input, 1: SPI clock, asynchronous to clk.
REQ-008 SHALL have port ncs, input, 1: SPI chip select, active-low.
REQ-009 SHALL have port copi, input, 1: controller-out data.
REQ-010 SHALL have port cipo, output, 1: peripheral-out data.
REQ-011 SHALL have port regs_out, output, NUM_REGS*DATA_W: register contents; reg k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port wr_strobe, output, NUM_REGS: one-cycle pulse on bit k when reg k is written.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a malformed frame.

Function
REQ-014 SHALL pass sclk, ncs and copi through SYNC_STAGES flops, then detect edges with one further flop; operation requires clk >= 8x sclk.
REQ-015 SHALL use SPI mode 0: sample copi on synchronised sclk rising, update cipo on synchronised sclk falling, MSB first.
REQ-016 Frame SHALL be FRAME_W = 1+ADDR_W+DATA_W bits: bit R/W (1=write), then address, then data.
REQ-017 FSM SHALL have states IDLE, SHIFT and COMMIT.
REQ-018 IDLE->SHIFT on ncs falling edge; bit counter and shift register cleared on that transition.
REQ-019 In SHIFT, each sclk rising edge SHALL shift in copi; counter increments, saturating at FRAME_W+1.
REQ-020 SHIFT->COMMIT on ncs rising edge; COMMIT->IDLE unconditionally the next cycle.
REQ-021 In COMMIT, a write frame with count==FRAME_W and address<NUM_REGS SHALL update that register and pulse its wr_strobe bit in the same cycle.
REQ-022 Commit latency SHALL be 1 clk after the detected ncs rising edge.
REQ-023 count!=FRAME_W at COMMIT SHALL discard the frame, leave registers unchanged and pulse frame_err.
REQ-024 Well-formed frame with address>=NUM_REGS SHALL be discarded silently, with no frame_err and no strobe.
REQ-025 sclk edges while in IDLE or COMMIT SHALL be ignored.
REQ-026 cipo SHALL be 0 whenever no read data is being shifted.
REQ-027 A new ncs falling edge in the cycle of COMMIT SHALL be honoured: FSM enters SHIFT next cycle, with no lost frame.

Reset
REQ-028 rst_n low SHALL force: all registers 0, regs_out 0, wr_strobe 0, frame_err 0, cipo 0, FSM IDLE, counter 0, synchronisers 0.
REQ-029 Reset during SHIFT SHALL abort the frame with no commit.
REQ-030 After reset release with ncs low, the FSM SHALL stay in IDLE until ncs has been seen high, so no partial frame is accepted.

Configuration
REQ-031 Macro SPI_REGBANK_READBACK_EN defined: a read frame (R/W=0) SHALL load reg[addr] into the output shifter once 1+ADDR_W bits are received.
REQ-032 With SPI_REGBANK_READBACK_EN defined: the loaded value SHALL be driven on cipo MSB first from the next sclk falling edge; addresses >= NUM_REGS SHALL read 0.
REQ-033 With SPI_REGBANK_READBACK_EN defined: read frames SHALL never modify registers or pulse wr_strobe, and length errors still pulse frame_err.
REQ-034 Macro SPI_REGBANK_READBACK_EN undefined: cipo SHALL be tied 0 and no output shifter built.
REQ-035 Macro SPI_REGBANK_READBACK_EN undefined: well-formed read frames SHALL be ignored with no frame_err; malformed ones still pulse frame_err.

Verification
REQ-036 Write 0x80F0 (R/W=1, addr 0, data 0xF0) -> reg0=0xF0, wr_strobe[0] pulses once, frame_err stays 0.
REQ-037 Write addr 4 data 0xA5, then addr 4 data 0x3C -> reg4=0x3C; other registers unchanged; two strobe pulses.
REQ-038 15-bit frame to addr 1, then 17-bit frame to addr 1 -> reg1 unchanged; frame_err pulses twice.
REQ-039 Write addr 0x7F data 0x55 -> no register change, no strobe, no frame_err.
REQ-040 Readback build: write reg2=0xC3, then read addr 2 -> cipo bits 1,1,0,0,0,0,1,1 across the last 8 sclk periods; without macro cipo stays 0.
REQ-041 Assert rst_n low mid-frame after 10 bits, release, then send a complete write -> aborted frame has no effect; new frame commits correctly.

Source files
------------

// File: rtl/spi_regbank.sv
// SPI mode-0 peripheral that writes a bank of DATA_W-bit registers from framed SPI writes.
// Optional readback of registers over cipo is built when SPI_REGBANK_READBACK_EN is defined.
`timescale 1ns/1ps
module spi_regbank #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_regbank: SYNC_STAGES must be at least 2");
  end
  if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_regs
    $error("spi_regbank: NUM_REGS out of range");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] ncs_sync_reg;
  logic [SYNC_STAGES-1:0] copi_sync_reg;
  logic                   sclk_d_reg;
  logic                   ncs_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= '0;
      ncs_sync_reg  <= '0;
      copi_sync_reg <= '0;
      sclk_d_reg    <= 1'b0;
      ncs_d_reg     <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], ncs};
      copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], copi};
      sclk_d_reg    <= sclk_sync_reg[SYNC_STAGES-1];
      ncs_d_reg     <= ncs_sync_reg[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_reg[SYNC_STAGES-1];
  assign copi_s    = copi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign ncs_rise  = ncs_s & ~ncs_d_reg;
  assign ncs_fall  = ~ncs_s & ncs_d_reg;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] shift_next;
  logic               armed_reg;

  assign shift_next = {shift_reg[FRAME_W-2:0], copi_s};

  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              addr_ok;
  logic              commit_wr;

  assign frame_rw   = shift_reg[FRAME_W-1];
  assign frame_addr = shift_reg[DATA_W +: ADDR_W];
  assign frame_data = shift_reg[DATA_W-1:0];
  assign addr_ok    = ({1'b0, frame_addr} < NUM_REGS_L);
  assign commit_wr  = (state_reg == COMMIT) && (cnt_reg == CNT_FULL) && frame_rw && addr_ok;

  logic frame_err_reg;

  // armed_reg keeps a chip select held low across reset release from opening a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      armed_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      if (ncs_s) begin
        armed_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (ncs_fall && armed_reg) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
            shift_reg <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state_reg <= COMMIT;
          end else if (sclk_rise) begin
            shift_reg <= shift_next;
            if (cnt_reg != CNT_SAT) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          if (cnt_reg != CNT_FULL) begin
            frame_err_reg <= 1'b1;
          end
          if (ncs_fall) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
            shift_reg <= '0;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] wr_strobe_reg;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic hit;
    assign hit = commit_wr && (frame_addr == ADDR_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_reg[gi]      <= '0;
        wr_strobe_reg[gi] <= 1'b0;
      end else begin
        wr_strobe_reg[gi] <= hit;
        if (hit) begin
          regs_reg[gi] <= frame_data;
        end
      end
    end

    assign regs_out[gi*DATA_W +: DATA_W] = regs_reg[gi];
  end

  assign wr_strobe = wr_strobe_reg;
  assign frame_err = frame_err_reg;

`ifdef SPI_REGBANK_READBACK_EN
  logic [DATA_W-1:0] out_shift_reg;
  logic              cipo_reg;
  logic              hdr_done;
  logic              rd_rw;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_val;

  // The header is complete on the rising edge that brings the count to 1+ADDR_W.
  assign hdr_done = (state_reg == SHIFT) && !ncs_rise && sclk_rise && (cnt_reg == CNT_W'(ADDR_W));
  assign rd_rw    = shift_next[ADDR_W];
  assign rd_addr  = shift_next[ADDR_W-1:0];

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) begin
        rd_val = regs_reg[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_shift_reg <= '0;
      cipo_reg      <= 1'b0;
    end else if (state_reg != SHIFT) begin
      out_shift_reg <= '0;
      cipo_reg      <= 1'b0;
    end else if (hdr_done && !rd_rw) begin
      out_shift_reg <= rd_val;
    end else if (sclk_fall) begin
      cipo_reg      <= out_shift_reg[DATA_W-1];
      out_shift_reg <= {out_shift_reg[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo = cipo_reg;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank: vector table of SPI frames plus back-to-back and reset sequences.
// Strobe/frame_err pulses are matched against a scoreboard queue filled when each frame is sent.
`timescale 1ns/1ps
module tb_spi_regbank;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;
  localparam int HALF     = 80;
`ifdef SPI_REGBANK_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       sclk;
  logic                       ncs;
  logic                       copi;
  logic                       cipo;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [NUM_REGS-1:0]        wr_strobe;
  logic                       frame_err;

  always #5 clk = ~clk;

  spi_regbank #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .regs_out(regs_out), .wr_strobe(wr_strobe), .frame_err(frame_err)
  );

  typedef struct {
    logic [NUM_REGS-1:0] strobe;
    logic                err;
    logic [DATA_W-1:0]   data;
    int                  addr;
  } evt_t;

  typedef struct {
    int                  nbits;
    logic [31:0]         frame;
    logic [NUM_REGS-1:0] strobe;
    logic                err;
    logic [DATA_W-1:0]   data;
    logic [31:0]         cipo_rb;
  } vec_t;

  evt_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  logic [31:0]       cap;
  logic [DATA_W-1:0] model [NUM_REGS];
  vec_t              vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_packed();
    logic [NUM_REGS*DATA_W-1:0] p;
    p = '0;
    for (int k = 0; k < NUM_REGS; k++) p[k*DATA_W +: DATA_W] = model[k];
    return p;
  endfunction

  task automatic push_evt(input logic [NUM_REGS-1:0] strobe, input logic err, input logic [DATA_W-1:0] data);
    evt_t e;
    e.strobe = strobe;
    e.err    = err;
    e.data   = data;
    e.addr   = 0;
    for (int k = 0; k < NUM_REGS; k++) if (strobe[k]) e.addr = k;
    sb.push_back(e);
    if (strobe != '0) model[e.addr] = data;
  endtask

  task automatic monitor();
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (wr_strobe !== '0 || frame_err !== 1'b0)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got strobe=0x%0h frame_err=%0b expected no pulse", wr_strobe, frame_err);
        end else begin
          e = sb.pop_front();
          check("wr_strobe", 64'(wr_strobe), 64'(e.strobe));
          check("frame_err", 64'(frame_err), 64'(e.err));
          if (!e.err) check("wr_data", 64'(regs_out[e.addr*DATA_W +: DATA_W]), 64'(e.data));
        end
      end
    end
  endtask

  task automatic frame_begin();
    cap = '0;
    ncs = 1'b0;
    #(2*HALF);
  endtask

  task automatic frame_bits(input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      #HALF;
      cap  = {cap[30:0], cipo};
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    copi = 1'b0;
  endtask

  task automatic frame_end();
    #HALF;
    ncs = 1'b1;
    #(3*HALF);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ncs   = 1'b1;
    sclk  = 1'b0;
    copi  = 1'b0;
    cap   = '0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

    // nbits, frame, strobe, err, data, cipo capture when readback is built
    vecs[0]  = '{16, 32'h80F0,  5'h01, 1'b0, 8'hF0, 32'h0};
    vecs[1]  = '{16, 32'h84A5,  5'h10, 1'b0, 8'hA5, 32'h0};
    vecs[2]  = '{16, 32'h843C,  5'h10, 1'b0, 8'h3C, 32'h0};
    vecs[3]  = '{15, 32'h40AA,  5'h00, 1'b1, 8'h00, 32'h0};
    vecs[4]  = '{17, 32'h103AA, 5'h00, 1'b1, 8'h00, 32'h0};
    vecs[5]  = '{16, 32'hFF55,  5'h00, 1'b0, 8'h00, 32'h0};
    vecs[6]  = '{16, 32'h82C3,  5'h04, 1'b0, 8'hC3, 32'h0};
    vecs[7]  = '{16, 32'h0200,  5'h00, 1'b0, 8'h00, 32'h00C3};
    vecs[8]  = '{16, 32'h7F00,  5'h00, 1'b0, 8'h00, 32'h0};
    vecs[9]  = '{15, 32'h0100,  5'h00, 1'b1, 8'h00, 32'h0061};
    vecs[10] = '{16, 32'h8511,  5'h00, 1'b0, 8'h00, 32'h0};
    vecs[11] = '{16, 32'h837E,  5'h08, 1'b0, 8'h7E, 32'h0};
    vecs[12] = '{16, 32'h0000,  5'h00, 1'b0, 8'h00, 32'h00F0};

    fork
      monitor();
    join_none

    repeat (4) @(negedge clk);
    check("reset_regs_out", 64'(regs_out), 64'h0);
    check("reset_wr_strobe", 64'(wr_strobe), 64'h0);
    check("reset_frame_err", 64'(frame_err), 64'h0);
    check("reset_cipo", 64'(cipo), 64'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].strobe != '0 || vecs[i].err) push_evt(vecs[i].strobe, vecs[i].err, vecs[i].data);
      frame_begin();
      frame_bits(vecs[i].nbits, vecs[i].frame);
      frame_end();
      check($sformatf("vec%0d_pending", i), 64'(sb.size()), 64'h0);
      check($sformatf("vec%0d_regs", i), 64'(regs_out), 64'(model_packed()));
      check($sformatf("vec%0d_cipo", i), 64'(cap), RB ? 64'(vecs[i].cipo_rb) : 64'h0);
      $display("vec %0d: nbits=%0d frame=0x%0h regs=0x%0h cipo_bits=0x%0h", i, vecs[i].nbits, vecs[i].frame, regs_out, cap);
    end

    // Back-to-back frames: ncs high for one clk so its falling edge lands in the commit cycle.
    push_evt(5'h01, 1'b0, 8'h11);
    push_evt(5'h02, 1'b0, 8'h22);
    frame_begin();
    frame_bits(16, 32'h8011);
    #HALF;
    @(negedge clk) ncs = 1'b1;
    @(negedge clk) ncs = 1'b0;
    #(2*HALF);
    frame_bits(16, 32'h8122);
    frame_end();
    check("b2b_pending", 64'(sb.size()), 64'h0);
    check("b2b_regs", 64'(regs_out), 64'(model_packed()));
    $display("b2b: regs=0x%0h", regs_out);

    // Reset after 10 bits with ncs held low; the remainder of that frame must be ignored.
    frame_begin();
    frame_bits(10, 32'h81AA >> 6);
    @(negedge clk) rst_n = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    repeat (3) @(negedge clk);
    check("midreset_regs", 64'(regs_out), 64'h0);
    check("midreset_strobe", 64'(wr_strobe), 64'h0);
    check("midreset_cipo", 64'(cipo), 64'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    frame_bits(6, 32'h81AA & 32'h3F);
    frame_end();
    check("aborted_pending", 64'(sb.size()), 64'h0);
    check("aborted_regs", 64'(regs_out), 64'h0);
    $display("aborted frame: regs=0x%0h", regs_out);

    push_evt(5'h02, 1'b0, 8'hAA);
    frame_begin();
    frame_bits(16, 32'h81AA);
    frame_end();
    check("post_reset_pending", 64'(sb.size()), 64'h0);
    check("post_reset_regs", 64'(regs_out), 64'(model_packed()));
    $display("post-reset write: regs=0x%0h", regs_out);

    repeat (10) @(negedge clk);
    check("final_pending", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
